// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer for the five-stage MIPS pipeline.
// Issues mult/multu/div/divu from E into a fixed-latency HI/LO unit, commits
// the result to HI/LO when the latency expires and stalls D while an HI/LO
// instruction there would collide with an operation in flight.
// Optional feature: define MDC_MADD_EN to also decode madd/maddu/msub/msubu
// (SPECIAL2 opcode) as multiply-accumulate start ops.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | unit free; start ops launch, mthi/mtlo write HI/LO directly
// S_BUSY | counting down the latency; result held in hi_p_q/lo_p_q
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        MDC_clk_i,
    input  logic        MDC_rst_n_i,
    input  logic [5:0]  MDC_op_D_i,
    input  logic [5:0]  MDC_fun_D_i,
    input  logic [5:0]  MDC_op_E_i,
    input  logic [5:0]  MDC_fun_E_i,
    input  logic [31:0] MDC_A_E_i,
    input  logic [31:0] MDC_B_E_i,
    output logic        MDC_busy_o,
    output logic        MDC_stall_D_o,
    output logic [31:0] MDC_hi_o,
    output logic [31:0] MDC_lo_o,
    output logic [31:0] MDC_mfout_E_o
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
`ifdef MDC_MADD_EN
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] FN_MADD     = 6'b000000;
    localparam logic [5:0] FN_MADDU    = 6'b000001;
    localparam logic [5:0] FN_MSUB     = 6'b000100;
    localparam logic [5:0] FN_MSUBU    = 6'b000101;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic [3:0] {
        K_NONE,
        K_MULT,
        K_MULTU,
        K_DIV,
        K_DIVU,
        K_MADD,
        K_MADDU,
        K_MSUB,
        K_MSUBU,
        K_MFHI,
        K_MTHI,
        K_MFLO,
        K_MTLO
    } md_kind_e;

    typedef enum logic [0:0] {
        S_IDLE,
        S_BUSY
    } state_e;

    function automatic md_kind_e decode(input logic [5:0] op, input logic [5:0] fn);
        md_kind_e k;
        k = K_NONE;
        if (op == OP_SPECIAL) begin
            case (fn)
                FN_MULT:  k = K_MULT;
                FN_MULTU: k = K_MULTU;
                FN_DIV:   k = K_DIV;
                FN_DIVU:  k = K_DIVU;
                FN_MFHI:  k = K_MFHI;
                FN_MTHI:  k = K_MTHI;
                FN_MFLO:  k = K_MFLO;
                FN_MTLO:  k = K_MTLO;
                default:  k = K_NONE;
            endcase
        end else begin
`ifdef MDC_MADD_EN
            if (op == OP_SPECIAL2) begin
                case (fn)
                    FN_MADD:  k = K_MADD;
                    FN_MADDU: k = K_MADDU;
                    FN_MSUB:  k = K_MSUB;
                    FN_MSUBU: k = K_MSUBU;
                    default:  k = K_NONE;
                endcase
            end
`else
            k = K_NONE;
`endif
        end
        return k;
    endfunction

    function automatic logic is_start_kind(input md_kind_e k);
        return (k == K_MULT) || (k == K_MULTU) || (k == K_DIV) || (k == K_DIVU) ||
               (k == K_MADD) || (k == K_MADDU) || (k == K_MSUB) || (k == K_MSUBU);
    endfunction

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_p_q;
    logic [31:0] lo_p_q;
    logic        wr_p_q;

    md_kind_e    kind_D;
    md_kind_e    kind_E;
    logic        start_E;

    logic [31:0] hi_p_d;
    logic [31:0] lo_p_d;
    logic        wr_p_d;
    logic [3:0]  cnt_d;

    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
`ifdef MDC_MADD_EN
    logic [63:0] acc;
`endif

    // Decode both stages and form the stall from the D instruction and E-stage activity.
    always_comb begin
        kind_D        = decode(MDC_op_D_i, MDC_fun_D_i);
        kind_E        = decode(MDC_op_E_i, MDC_fun_E_i);
        start_E       = is_start_kind(kind_E) && (state_q == S_IDLE);
        MDC_stall_D_o = (kind_D != K_NONE) && ((state_q == S_BUSY) || start_E);
    end

    // Operation result computed from the E operands; latched into hi_p/lo_p on start.
    always_comb begin
        prod_s     = 64'($signed(MDC_A_E_i)) * 64'($signed(MDC_B_E_i));
        prod_u     = {32'b0, MDC_A_E_i} * {32'b0, MDC_B_E_i};

        // One shared unsigned divider; signed division runs on magnitudes and
        // fixes signs afterwards (quotient toward zero, remainder follows dividend).
        // The 0x80000000 / -1 corner falls out naturally as 0x80000000 rem 0.
        div_signed = (kind_E == K_DIV);
        a_neg      = div_signed && MDC_A_E_i[31];
        b_neg      = div_signed && MDC_B_E_i[31];
        dvd        = a_neg ? (32'd0 - MDC_A_E_i) : MDC_A_E_i;
        dvs        = b_neg ? (32'd0 - MDC_B_E_i) : MDC_B_E_i;
        quo_mag    = (dvs == 32'd0) ? 32'd0 : (dvd / dvs);
        rem_mag    = (dvs == 32'd0) ? 32'd0 : (dvd % dvs);
        quo        = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;
`ifdef MDC_MADD_EN
        acc        = {hi_q, lo_q};
`endif

        hi_p_d = hi_p_q;
        lo_p_d = lo_p_q;
        wr_p_d = 1'b1;
        cnt_d  = MULT_N;
        case (kind_E)
            K_MULT:  {hi_p_d, lo_p_d} = prod_s;
            K_MULTU: {hi_p_d, lo_p_d} = prod_u;
            K_DIV, K_DIVU: begin
                hi_p_d = rem;
                lo_p_d = quo;
                wr_p_d = (MDC_B_E_i != 32'd0);
                cnt_d  = DIV_N;
            end
`ifdef MDC_MADD_EN
            K_MADD:  {hi_p_d, lo_p_d} = acc + prod_s;
            K_MADDU: {hi_p_d, lo_p_d} = acc + prod_u;
            K_MSUB:  {hi_p_d, lo_p_d} = acc - prod_s;
            K_MSUBU: {hi_p_d, lo_p_d} = acc - prod_u;
`endif
            default: ;
        endcase
    end

    // Sequencer: launch, count down, commit; mthi/mtlo only land while idle.
    always_ff @(posedge MDC_clk_i) begin
        if (!MDC_rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
            wr_p_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_E) begin
                        state_q <= S_BUSY;
                        cnt_q   <= cnt_d;
                        hi_p_q  <= hi_p_d;
                        lo_p_q  <= lo_p_d;
                        wr_p_q  <= wr_p_d;
                    end else if (kind_E == K_MTHI) begin
                        hi_q <= MDC_A_E_i;
                    end else if (kind_E == K_MTLO) begin
                        lo_q <= MDC_A_E_i;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                        if (wr_p_q) begin
                            hi_q <= hi_p_q;
                            lo_q <= lo_p_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Architectural outputs and the zero-latency move-from path.
    always_comb begin
        MDC_busy_o = (state_q == S_BUSY);
        MDC_hi_o   = hi_q;
        MDC_lo_o   = lo_q;
        case (kind_E)
            K_MFHI:  MDC_mfout_E_o = hi_q;
            K_MFLO:  MDC_mfout_E_o = lo_q;
            default: MDC_mfout_E_o = 32'd0;
        endcase
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the five-stage MIPS pipeline. It issues `mult`, `multu`, `div` and `divu` from the E stage into a multi-cycle HI/LO unit. It holds the unit busy for a fixed latency and commits results to HI/LO. It raises the D-stage stall whenever an HI/LO instruction in D would conflict with an operation in flight. The block sits beside the ALU in E and is fed by the instruction field splitter's op/funct outputs from D and E.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1..15.

Ports:
- `MDC_clk_i`  in  1  — single clock; all state changes on the rising edge.
- `MDC_rst_n_i`  in  1  — reset, synchronous and active-low.
- `MDC_op_D_i`  in  6  — D-stage opcode.
- `MDC_fun_D_i`  in  6  — D-stage funct.
- `MDC_op_E_i`  in  6  — E-stage opcode.
- `MDC_fun_E_i`  in  6  — E-stage funct.
- `MDC_A_E_i`  in  32  — rs operand value in E.
- `MDC_B_E_i`  in  32  — rt operand value in E.
- `MDC_busy_o`  out  1  — an operation is in flight.
- `MDC_stall_D_o`  out  1  — freeze F/D and insert an E bubble.
- `MDC_hi_o`  out  32  — architectural HI.
- `MDC_lo_o`  out  32  — architectural LO.
- `MDC_mfout_E_o`  out  32  — HI for `mfhi` in E, LO for `mflo` in E, otherwise 0.

## Operation
Decode rules:
- An instruction is an MD instruction when op = 000000 and funct is one of:
  - start ops: `mult` 011000, `multu` 011001, `div` 011010, `divu` 011011;
  - move ops: `mfhi` 010000, `mthi` 010001, `mflo` 010010, `mtlo` 010011.
- `start_E` is true when E holds a start op and the state is IDLE.

State machine:
- IDLE → BUSY on `start_E`. The counter loads `MULT_CYCLES` or `DIV_CYCLES`, and the result is computed from `MDC_A_E_i`/`MDC_B_E_i` into the pending registers `hi_p`/`lo_p`.
- BUSY: the counter decrements every cycle.
- BUSY → IDLE when the counter = 1. On that edge HI←`hi_p` and LO←`lo_p`.
- A start op seen in E while BUSY is ignored. The stall makes this unreachable.

Arithmetic:
- `mult`: {HI,LO} = signed 32×32 → 64.
- `multu`: {HI,LO} = unsigned 32×32 → 64.
- `div`: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- `divu`: unsigned quotient and remainder.
- Divide by zero (B = 0): full busy time, but HI/LO are not written.

Move ops:
- `mthi`/`mtlo` in E while IDLE write HI/LO from `MDC_A_E_i` at the end of that cycle.
- `mfhi`/`mflo` read the current HI/LO combinationally.

Stall:
- `MDC_stall_D_o` = (D holds an MD instruction) && (`MDC_busy_o` || `start_E`).
- Non-MD instructions in D never stall.

## Timing
- Reset: state IDLE, counter 0, HI = LO = `hi_p` = `lo_p` = 0.
  - Reset outputs: `MDC_busy_o` = 0, `MDC_stall_D_o` = 0 unless D holds an MD op and E holds a start op, `MDC_mfout_E_o` = 0 unless E holds `mfhi`/`mflo`.
  - Reset asserted mid-operation aborts it: no commit, and HI/LO = 0.
- Start in cycle t:
  - `MDC_busy_o` = 1 in cycles t+1 through t+N (N = configured latency).
  - HI/LO hold new values from cycle t+N+1.
  - State is IDLE at t+N+1, and a new start may occur in t+N+1.
- `MDC_stall_D_o` is combinational. It covers cycles t..t+N for an MD op waiting in D.
- `mthi`/`mtlo` are visible on `MDC_hi_o`/`MDC_lo_o` in the next cycle.
- `mfout` has zero latency.
- A move op in E during `start_E` cannot occur, because E holds a single instruction.

## Configuration
- `MDC_MADD_EN` defined: `madd` (op 011100, funct 000000), `maddu` (000001), `msub` (000100) and `msubu` (000101) are also start ops.
  - They use `MULT_CYCLES`.
  - Result: {HI,LO} ± product (signed or unsigned), with the accumulator sampled at start.
  - They count as MD instructions for the stall rule.
- `MDC_MADD_EN` undefined: these encodings are not decoded. They cause no stall, no start, and no HI/LO change.

## Test plan
- **Reset:** hold `MDC_rst_n_i` = 0 for 2 edges → HI = LO = 0, busy = 0, stall = 0.
- **Signed multiply:** `mult`, A = 0xFFFFFFFE (−2), B = 3 →
  - busy high for exactly 5 cycles;
  - HI = 0xFFFFFFFF and LO = 0xFFFFFFFA in cycle t+6.
- **Signed divide with stall:** `div` A = −7, B = 2, with `mflo` held in D →
  - stall for cycles t..t+10;
  - LO = 0xFFFFFFFD, HI = 0xFFFFFFFF;
  - `mfout` = 0xFFFFFFFD once `mflo` reaches E.
- **Divide by zero:** preload HI = 0x11, LO = 0x22 via `mthi`/`mtlo`, then `divu` B = 0 → busy 10 cycles, HI/LO unchanged.
- **Reset mid-operation:** `multu` 0xFFFFFFFF × 0xFFFFFFFF, assert reset in cycle t+3 → no commit, HI = LO = 0, busy = 0.
- **`MDC_MADD_EN`:** with HI:LO = 0:5, `madd` 3×4 → HI:LO = 0:17 (LO = 0x11) after 5 cycles. Without the macro, the same stimulus leaves HI:LO = 0:5 with no stall.
